sign_extender: RTL and testbench
================================

// Module: sign_extender
// PURPOSE
//  RV32I immediate generator for the decode stage: extracts the immediate field of a 32-bit
//  instruction per the format chosen by the control unit and sign-/zero-extends it to 32 bits.
//  Primary path is purely combinational, feeding the ALU B-mux and the branch/jump adder.
//  An optional registered copy serves pipelined datapaths.
// PARAMETERS
//  REG_OUT  1  1: imm_ext_q is a registered copy of imm_ext; 0: imm_ext_q is tied to 32'h0
// PORTS
//  clk         in   1   single clock; only the optional output register uses it
//  rst         in   1   asynchronous, active-high reset
//  instr_full  in   32  raw instruction word
//  sel_ext     in   3   immediate format select
//  imm_ext     out  32  extended immediate, combinational
//  imm_ext_q   out  32  imm_ext registered on rising clk (REG_OUT=1)
//  sel_err     out  1   combinational; 1 when sel_ext is a reserved code
// BEHAVIOUR
//  - Clocking: one clock; reset is asynchronous and active-high.
//  - imm_ext and sel_err are combinational from instr_full/sel_ext only; no latency.
//  - imm_ext and sel_err are independent of clk and rst; they are valid whenever inputs are stable.
//  - sel_ext encoding, with i = instr_full:
//    - 000 I: {{20{i[31]}}, i[31:20]}
//    - 001 S: {{20{i[31]}}, i[31:25], i[11:7]}
//    - 010 B: {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
//    - 011 J: {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
//    - 100 U: {i[31:12], 12'h000} (no extension needed)
//    - 101 Z: {27'b0, i[19:15]} (CSR zimm, zero-extended)
//    - 110, 111: reserved -> imm_ext = 32'h0, sel_err = 1
//  - sel_err = 0 for codes 000-101.
//  - The sign bit is always instr_full[31] for I/S/B/J; bit 0 of B and J is forced to 0.
//  - No X propagation from unused instruction bits; X on sel_ext yields X output (not masked).
//  - imm_ext_q: rst=1 forces 32'h0 immediately (async), regardless of clk.
//    Otherwise it loads imm_ext on each rising clk edge; no enable.
//  - Reset deassertion takes effect at the next rising clk edge; reset asserted mid-operation
//    clears imm_ext_q and leaves the combinational outputs unaffected.
//  - The decoder is a full case with a default arm, producing no latches.
// STRUCTURE
//  - Shared package: localparams IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_J=3'b011,
//    IMM_U=3'b100, IMM_Z=3'b101; XLEN=32. The control unit uses the same constants.
//  - One always_comb/case decoder plus one async-reset always block for imm_ext_q.
//  - No sub-module; the block is small enough to remain flat.
// TESTING
//  - instr=ffb00193 (addi x3,x0,-5), sel=000 -> imm_ext=fffffffb, sel_err=0
//  - instr=00500093, sel=000 -> 00000005
//  - instr=fe512e23 (sw x5,-4(x2)), sel=001 -> fffffffc
//  - instr=80000063, sel=010 -> fffff000; instr=800000ef, sel=011 -> fff00000
//  - instr=12345037, sel=100 -> 12345000; instr=000fd073, sel=101 -> 0000001f
//  - sel=111 -> imm_ext=0, sel_err=1.
//    Register check: rst=1 -> imm_ext_q=0 before any clk edge.
//    Then rst=0, sel=000, instr=ffb00193; after one rising clk edge -> imm_ext_q=fffffffb.

Source files
------------

// File: rtl/sign_extender_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sign_extender_pkg
//  Description : Immediate-format select codes and datapath width shared by
//                the immediate generator and the control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package sign_extender_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;
    localparam logic [2:0] IMM_RSV0 = 3'b110;
    localparam logic [2:0] IMM_RSV1 = 3'b111;

endpackage : sign_extender_pkg
`default_nettype wire

// File: rtl/sign_extender.sv
`default_nettype none
// ============================================================================
//  Module      : sign_extender
//  Description : RV32I immediate generator with an optional registered copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module sign_extender
    import sign_extender_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_full,
    input  logic [2:0]      sel_ext,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] imm_ext_q,
    output logic            sel_err
);

    logic [XLEN-1:0] imm_d;
    logic            err_d;

    always_comb begin
        imm_d = '0;
        err_d = 1'b0;
        case (sel_ext)
            IMM_I: imm_d = {{20{instr_full[31]}}, instr_full[31:20]};
            IMM_S: imm_d = {{20{instr_full[31]}}, instr_full[31:25], instr_full[11:7]};
            IMM_B: imm_d = {{19{instr_full[31]}}, instr_full[31], instr_full[7],
                            instr_full[30:25], instr_full[11:8], 1'b0};
            IMM_J: imm_d = {{11{instr_full[31]}}, instr_full[31], instr_full[19:12],
                            instr_full[20], instr_full[30:21], 1'b0};
            IMM_U: imm_d = {instr_full[31:12], 12'h000};
            IMM_Z: imm_d = {27'b0, instr_full[19:15]};
            IMM_RSV0, IMM_RSV1: begin
                imm_d = '0;
                err_d = 1'b1;
            end
            // Only reachable with an unknown select; keep it visible rather than masking it.
            default: begin
                imm_d = 'x;
                err_d = 1'bx;
            end
        endcase
    end

    assign imm_ext = imm_d;
    assign sel_err = err_d;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [XLEN-1:0] imm_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    imm_q <= '0;
                end else begin
                    imm_q <= imm_d;
                end
            end

            assign imm_ext_q = imm_q;
        end else begin : g_no_reg_out
            assign imm_ext_q = '0;
        end
    endgenerate

endmodule : sign_extender
`default_nettype wire

// File: tb/tb_sign_extender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sign_extender
//  Description : Self-checking bench for sign_extender against an arithmetic
//                model of the RV32I immediate formats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_extender;

    logic        clk;
    logic        rst;
    logic [31:0] instr_full;
    logic [2:0]  sel_ext;
    logic [31:0] imm_ext;
    logic [31:0] imm_ext_q;
    logic        sel_err;

    int tests;
    int fails;

    sign_extender #(.REG_OUT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_full (instr_full),
        .sel_ext    (sel_ext),
        .imm_ext    (imm_ext),
        .imm_ext_q  (imm_ext_q),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate value as a signed integer built from weighted instruction fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] sel);
        longint v;
        longint sgn;
        sgn = longint'(i[31]);
        case (sel)
            3'd0: v = longint'(i[31:20]) - sgn * 4096;
            3'd1: v = longint'(i[31:25]) * 32 + longint'(i[11:7]) - sgn * 4096;
            3'd2: v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                      + longint'(i[11:8]) * 2 - sgn * 4096;
            3'd3: v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                      + longint'(i[30:21]) * 2 - sgn * 1048576;
            3'd4: v = longint'(i[31:12]) * 4096;
            3'd5: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic logic ref_err(input logic [2:0] sel);
        return (sel > 3'd5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_comb(input logic [31:0] ins, input logic [2:0] sel);
        instr_full = ins;
        sel_ext    = sel;
        #1;
        chk("imm_ext", imm_ext, ref_imm(ins, sel));
        chk("sel_err", {31'b0, sel_err}, {31'b0, ref_err(sel)});
    endtask

    initial begin
        logic [31:0] r_ins;
        logic [2:0]  r_sel;
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        instr_full = 32'h0;
        sel_ext    = 3'b000;

        // Async reset clears the register before any clock edge.
        #2;
        chk("reset_q", imm_ext_q, 32'h0);

        // Directed decode vectors, checked against hand-derived constants.
        instr_full = 32'hffb00193; sel_ext = 3'b000; #1;
        chk("addi_neg", imm_ext, 32'hfffffffb);
        chk("addi_err", {31'b0, sel_err}, 32'h0);
        instr_full = 32'h00500093; sel_ext = 3'b000; #1;
        chk("addi_pos", imm_ext, 32'h00000005);
        instr_full = 32'hfe512e23; sel_ext = 3'b001; #1;
        chk("sw_neg", imm_ext, 32'hfffffffc);
        instr_full = 32'h80000063; sel_ext = 3'b010; #1;
        chk("branch_min", imm_ext, 32'hfffff000);
        instr_full = 32'h800000ef; sel_ext = 3'b011; #1;
        chk("jal_min", imm_ext, 32'hfff00000);
        instr_full = 32'h12345037; sel_ext = 3'b100; #1;
        chk("lui", imm_ext, 32'h12345000);
        instr_full = 32'h000fd073; sel_ext = 3'b101; #1;
        chk("zimm", imm_ext, 32'h0000001f);
        instr_full = 32'hffffffff; sel_ext = 3'b111; #1;
        chk("rsv7_imm", imm_ext, 32'h0);
        chk("rsv7_err", {31'b0, sel_err}, 32'h1);
        sel_ext = 3'b110; #1;
        chk("rsv6_imm", imm_ext, 32'h0);
        chk("rsv6_err", {31'b0, sel_err}, 32'h1);
        // Bit 0 of B/J is forced low even when every instruction bit is set.
        sel_ext = 3'b010; #1;
        chk("branch_ones", imm_ext, 32'hfffffffe);
        sel_ext = 3'b011; #1;
        chk("jal_ones", imm_ext, 32'hfffffffe);
        sel_ext = 3'b101; #1;
        chk("zimm_ones", imm_ext, 32'h0000001f);
        // Reset still held: register stays cleared across an edge.
        @(posedge clk); #1;
        chk("reset_hold_q", imm_ext_q, 32'h0);

        // Release reset and load one value.
        @(negedge clk);
        rst = 1'b0;
        instr_full = 32'hffb00193; sel_ext = 3'b000;
        @(posedge clk); #1;
        chk("reg_load", imm_ext_q, 32'hfffffffb);

        // Randomized decode plus register follow-through.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            r_ins = $urandom;
            r_sel = 3'($urandom_range(0, 7));
            apply_comb(r_ins, r_sel);
            @(posedge clk); #1;
            chk("reg_rand", imm_ext_q, ref_imm(r_ins, r_sel));
        end

        // Reset asserted mid-cycle clears the register but not the decoder.
        @(negedge clk);
        instr_full = 32'hfe512e23; sel_ext = 3'b001;
        @(posedge clk); #1;
        chk("pre_async_q", imm_ext_q, 32'hfffffffc);
        #2 rst = 1'b1;
        #1;
        chk("async_clear_q", imm_ext_q, 32'h0);
        chk("async_comb", imm_ext, 32'hfffffffc);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_release_q", imm_ext_q, 32'hfffffffc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sign_extender
`default_nettype wire
